unidade_busca: RTL and testbench

//   Instruction fetch/issue unit, the upstream end of the control interface: holds PC and IR,

---
 rtl/unidade_busca.sv | 154 +++++++++++++++
 tb/tb_unidade_busca.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// unidade_busca -- instruction fetch/issue unit.
// Holds PC and IR, fetches over a req/ack handshake and presents the opcode
// to Controle. Chooses the next PC from Controle's EscCP/EscCondCP/FonteCP,
// the ULA zero flag and the ULA result.
// Optional feature macro: BUSCA_TIMEOUT_EN (sticky fetch-timeout flag).
module unidade_busca #(
   parameter int LARG_END       = 8,
   parameter int LARG_INSTR     = 16,
   parameter int PC_RESET       = 0,
   parameter int TIMEOUT_CICLOS = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [LARG_END-1:0]   mem_end,
   input  logic                  mem_ack,
   input  logic [LARG_INSTR-1:0] mem_rdata,
   output logic [LARG_INSTR-1:0] ir,
   output logic [3:0]            opcode,
   output logic                  instr_valida,
   input  logic                  parar,
   input  logic                  EscCP,
   input  logic                  EscCondCP,
   input  logic [1:0]            FonteCP,
   input  logic                  ula_zero,
   input  logic [LARG_END-1:0]   ula_res,
   output logic [LARG_END-1:0]   pc,
   output logic                  erro_busca
);

   typedef enum logic [1:0] {
      BUSCA_OCIOSA = 2'b00,
      BUSCA_BUSCA  = 2'b01,
      BUSCA_EXEC   = 2'b10
   } estado_t;

   estado_t               estado_q, estado_d;
   logic [LARG_END-1:0]   pc_q, pc_d;
   logic [LARG_INSTR-1:0] ir_q, ir_d;
   logic [LARG_END-1:0]   pc_mais1_s;
   logic [LARG_END-1:0]   pc_prox_s;
   logic                  tomar_s;

   // PC successor: unsigned, wraps modulo 2^LARG_END
   assign pc_mais1_s = pc_q + {{(LARG_END-1){1'b0}}, 1'b1};
   assign tomar_s    = EscCP & (~EscCondCP | ula_zero);

   // Next-PC selection; anything not taken falls through to pc+1
   always_comb begin
      pc_prox_s = pc_mais1_s;
      if (tomar_s) begin
         case (FonteCP)
            2'b01:   pc_prox_s = ula_res;
            2'b10:   pc_prox_s = ir_q[LARG_END-1:0];
            default: pc_prox_s = pc_mais1_s;
         endcase
      end else begin
         pc_prox_s = pc_mais1_s;
      end
   end

   // Fetch/execute FSM next state, PC and IR updates
   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      case (estado_q)
         BUSCA_OCIOSA: begin
            estado_d = BUSCA_BUSCA;
         end
         BUSCA_BUSCA: begin
            if (mem_ack) begin
               ir_d     = mem_rdata;
               estado_d = BUSCA_EXEC;
            end else begin
               estado_d = BUSCA_BUSCA;
            end
         end
         BUSCA_EXEC: begin
            if (parar) begin
               estado_d = BUSCA_EXEC;
            end else begin
               pc_d     = pc_prox_s;
               estado_d = BUSCA_BUSCA;
            end
         end
         default: begin
            estado_d = BUSCA_OCIOSA;
         end
      endcase
   end

   // State, PC and IR registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= BUSCA_OCIOSA;
         pc_q     <= LARG_END'(PC_RESET);
         ir_q     <= {LARG_INSTR{1'b0}};
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
      end
   end

`ifdef BUSCA_TIMEOUT_EN
   localparam int LARG_CONT = $clog2(TIMEOUT_CICLOS + 1);

   logic [LARG_CONT-1:0] cont_q, cont_d;
   logic                 erro_q, erro_d;

   // Wait counter: counts un-acked BUSCA cycles, flags and restarts at the limit
   always_comb begin
      cont_d = cont_q;
      erro_d = erro_q;
      if ((estado_q == BUSCA_BUSCA) && !mem_ack) begin
         if (cont_q == LARG_CONT'(TIMEOUT_CICLOS - 1)) begin
            cont_d = {LARG_CONT{1'b0}};
            erro_d = 1'b1;
         end else begin
            cont_d = cont_q + LARG_CONT'(1);
         end
      end else begin
         cont_d = {LARG_CONT{1'b0}};
      end
   end

   // Timeout counter and sticky error flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_q <= {LARG_CONT{1'b0}};
         erro_q <= 1'b0;
      end else begin
         cont_q <= cont_d;
         erro_q <= erro_d;
      end
   end

   assign erro_busca = erro_q;
`else
   logic unused_s;
   assign unused_s   = (TIMEOUT_CICLOS == 0);
   assign erro_busca = 1'b0;
`endif

   // Moore decodes of the registers
   assign mem_req      = (estado_q == BUSCA_BUSCA);
   assign instr_valida = (estado_q == BUSCA_EXEC);
   assign mem_end      = pc_q;
   assign pc           = pc_q;
   assign ir           = ir_q;
   assign opcode       = ir_q[LARG_INSTR-1 -: 4];

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed cases plus randomized
// instructions checked against a per-instruction reference model.
module tb_unidade_busca;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [7:0]  mem_end;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic        instr_valida;
   logic        parar;
   logic        EscCP;
   logic        EscCondCP;
   logic [1:0]  FonteCP;
   logic        ula_zero;
   logic [7:0]  ula_res;
   logic [7:0]  pc;
   logic        erro_busca;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] pc_m;
   logic       erro_m;

   unidade_busca dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_end(mem_end),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .opcode(opcode),
      .instr_valida(instr_valida), .parar(parar), .EscCP(EscCP),
      .EscCondCP(EscCondCP), .FonteCP(FonteCP), .ula_zero(ula_zero),
      .ula_res(ula_res), .pc(pc), .erro_busca(erro_busca)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
      end
   endtask

   // expected next PC from the architectural rule, plain arithmetic
   function automatic logic [7:0] prox_pc(input logic [7:0] p, input logic [15:0] instr,
                                          input logic esc, input logic cond,
                                          input logic [1:0] fonte, input logic zero,
                                          input logic [7:0] res);
      int alvo;
      alvo = (int'(p) + 1) % 256;
      if (esc && (!cond || zero)) begin
         if (fonte == 2'd1) alvo = int'(res);
         else if (fonte == 2'd2) alvo = int'(instr) % 256;
      end
      return alvo[7:0];
   endfunction

   task automatic reinicia();
      rst_n = 1'b0;
      #1;
      pc_m   = 8'h00;
      erro_m = 1'b0;
      verifica("rst_mem_req", {31'd0, mem_req}, 32'd0);
      verifica("rst_pc", {24'd0, pc}, 32'd0);
      verifica("rst_valida", {31'd0, instr_valida}, 32'd0);
      verifica("rst_ir", {16'd0, ir}, 32'd0);
      verifica("rst_erro", {31'd0, erro_busca}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      verifica("idle_mem_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      verifica("busca_mem_req", {31'd0, mem_req}, 32'd1);
      verifica("busca_mem_end", {24'd0, mem_end}, 32'd0);
   endtask

   // One instruction: starts and ends at a negedge with the DUT in BUSCA
   task automatic instrucao(input int atraso, input logic [15:0] rd, input int paradas,
                            input logic esc, input logic cond, input logic [1:0] fonte,
                            input logic zero, input logic [7:0] res);
      logic [7:0] pc_ant;
      for (int k = 0; k < atraso; k++) begin
         verifica("wait_mem_req", {31'd0, mem_req}, 32'd1);
         verifica("wait_mem_end", {24'd0, mem_end}, {24'd0, pc_m});
         verifica("wait_valida", {31'd0, instr_valida}, 32'd0);
         mem_ack   = 1'b0;
         mem_rdata = 16'($urandom);
         @(negedge clk);
      end
      verifica("ack_mem_req", {31'd0, mem_req}, 32'd1);
      verifica("ack_mem_end", {24'd0, mem_end}, {24'd0, pc_m});
      verifica("ack_erro", {31'd0, erro_busca}, {31'd0, erro_m});
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      for (int s = 0; s <= paradas; s++) begin
         verifica("exec_ir", {16'd0, ir}, {16'd0, rd});
         verifica("exec_opcode", {28'd0, opcode}, {28'd0, rd[15:12]});
         verifica("exec_valida", {31'd0, instr_valida}, 32'd1);
         verifica("exec_mem_req", {31'd0, mem_req}, 32'd0);
         verifica("exec_pc", {24'd0, pc}, {24'd0, pc_m});
         if (s < paradas) begin
            // stalled: control inputs and stray acks must be ignored
            parar     = 1'b1;
            mem_ack   = 1'($urandom);
            EscCP     = 1'($urandom);
            EscCondCP = 1'($urandom);
            FonteCP   = 2'($urandom);
            ula_zero  = 1'($urandom);
            ula_res   = 8'($urandom);
            @(negedge clk);
            mem_ack   = 1'b0;
         end else begin
            parar     = 1'b0;
            EscCP     = esc;
            EscCondCP = cond;
            FonteCP   = fonte;
            ula_zero  = zero;
            ula_res   = res;
            @(negedge clk);
         end
      end
      pc_ant = pc_m;
      pc_m   = prox_pc(pc_ant, rd, esc, cond, fonte, zero, res);
      EscCP     = 1'($urandom);
      EscCondCP = 1'($urandom);
      FonteCP   = 2'($urandom);
      verifica("next_pc", {24'd0, pc}, {24'd0, pc_m});
      verifica("next_mem_req", {31'd0, mem_req}, 32'd1);
      verifica("next_erro", {31'd0, erro_busca}, {31'd0, erro_m});
   endtask

   initial begin
      mem_ack = 1'b0; mem_rdata = 16'h0000; parar = 1'b0;
      EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00; ula_zero = 1'b0; ula_res = 8'h00;
      pc_m = 8'h00; erro_m = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      reinicia();

      // sequential: 0x0123, pc -> 0x01
      instrucao(0, 16'h0123, 0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
      verifica("seq_pc_const", {24'd0, pc}, 32'h01);
      // jump to immediate of 0xB042
      instrucao(0, 16'hB042, 0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00);
      verifica("jump_pc_const", {24'd0, pc}, 32'h42);
      // jump to 0xFF via ULA result, then wrap
      instrucao(1, 16'h1000, 0, 1'b1, 1'b0, 2'b01, 1'b0, 8'hFF);
      verifica("to_ff_const", {24'd0, pc}, 32'hFF);
      instrucao(0, 16'h2000, 0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
      verifica("wrap_pc_const", {24'd0, pc}, 32'h00);
      // branch taken / not taken
      instrucao(0, 16'h3000, 0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h30);
      verifica("br_taken_const", {24'd0, pc}, 32'h30);
      instrucao(0, 16'h3000, 0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h55);
      verifica("br_not_const", {24'd0, pc}, 32'h31);
      // stall 3 cycles with ack pulses, then delayed ack of 4 cycles
      instrucao(0, 16'h4ABC, 3, 1'b0, 1'b0, 2'b01, 1'b0, 8'h77);
      verifica("stall_pc_const", {24'd0, pc}, 32'h32);
      instrucao(4, 16'h5DEF, 0, 1'b1, 1'b0, 2'b11, 1'b0, 8'h00);
      verifica("delay_pc_const", {24'd0, pc}, 32'h33);

      // randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         instrucao(int'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
      end

      // reset asserted mid-EXEC
      mem_ack = 1'b1; mem_rdata = 16'hABCD;
      @(negedge clk);
      mem_ack = 1'b0;
      verifica("pre_rst_valida", {31'd0, instr_valida}, 32'd1);
      reinicia();

      // fetch timeout: 15 un-acked BUSCA cycles
      for (int i = 0; i < 15; i++) begin
         verifica("to_before", {31'd0, erro_busca}, 32'd0);
         verifica("to_mem_req", {31'd0, mem_req}, 32'd1);
         @(negedge clk);
      end
`ifdef BUSCA_TIMEOUT_EN
      erro_m = 1'b1;
`endif
      verifica("to_flag", {31'd0, erro_busca}, {31'd0, erro_m});
      verifica("to_retry", {31'd0, mem_req}, 32'd1);
      instrucao(0, 16'h6001, 0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
      instrucao(2, 16'h7002, 1, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00);
      verifica("to_sticky", {31'd0, erro_busca}, {31'd0, erro_m});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
